// File: rtl/controller_apb_pwm.sv
// ============================================================================
//  Module      : controller_apb_pwm
//  Description : APB3 slave PWM generator, NUM_CH channels on a shared period
//                counter with double-buffered period/duty and period IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_apb_pwm #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic              FAB_CLK,
   input  logic              M2FRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [7:0]        PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [NUM_CH-1:0] PWM_OUT,
   output logic              IRQ
);

   localparam logic [5:0] c_IDX_CTRL   = 6'd0;
   localparam logic [5:0] c_IDX_PERIOD = 6'd1;
   localparam logic [5:0] c_IDX_DUTY0  = 6'd2;
   localparam logic [5:0] c_IDX_STATUS = 6'd6;
   localparam logic [5:0] c_IDX_COUNT  = 6'd7;

   logic              r_en;
   logic              r_irq_en;
   logic              r_pif;
   logic              r_irq;
   logic [CNT_W-1:0]  r_period_sh;
   logic [CNT_W-1:0]  r_period_a;
   logic [CNT_W-1:0]  r_duty_sh [NUM_CH];
   logic [CNT_W-1:0]  r_duty_a  [NUM_CH];
   logic [CNT_W-1:0]  r_cnt;
   logic [NUM_CH-1:0] r_pwm;

   logic [5:0]        w_idx;
   logic              w_access;
   logic              w_hit_ctrl;
   logic              w_hit_period;
   logic              w_hit_duty;
   logic              w_hit_status;
   logic              w_hit_count;
   logic              w_valid;
   logic              w_wr;
   logic              w_rd;
   logic              w_en_rise;
   logic              w_wrap;
   logic              w_load;
   logic [NUM_CH-1:0] w_pwm_next;
   logic [31:0]       w_rdata;
   logic              w_unused_bits;

   assign w_idx        = PADDR[7:2];
   assign w_access     = PSEL & PENABLE;
   assign w_hit_ctrl   = (w_idx == c_IDX_CTRL);
   assign w_hit_period = (w_idx == c_IDX_PERIOD);
   assign w_hit_duty   = (w_idx >= c_IDX_DUTY0) && (w_idx < 6'(2 + NUM_CH));
   assign w_hit_status = (w_idx == c_IDX_STATUS);
   assign w_hit_count  = (w_idx == c_IDX_COUNT);
   assign w_valid      = w_hit_ctrl | w_hit_period | w_hit_duty | w_hit_status | w_hit_count;
   assign w_wr         = w_access & PWRITE & w_valid;
   assign w_rd         = w_access & ~PWRITE & w_valid;

   // Actives reload either when the generator is switched on or at period wrap
   assign w_en_rise = w_wr & w_hit_ctrl & PWDATA[0] & ~r_en;
   assign w_wrap    = r_en & (r_cnt == r_period_a);
   assign w_load    = w_en_rise | w_wrap;

   assign w_unused_bits = ^{PADDR[1:0], PWDATA[31:CNT_W]};

   always_comb begin
      w_pwm_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pwm_next[i] = r_en & (r_cnt < r_duty_a[i]);
      end
   end

   always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
      if (!M2FRESETn) begin
         r_en        <= 1'b0;
         r_irq_en    <= 1'b0;
         r_pif       <= 1'b0;
         r_irq       <= 1'b0;
         r_period_sh <= '0;
         r_period_a  <= '0;
         r_cnt       <= '0;
         r_pwm       <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_duty_sh[i] <= '0;
            r_duty_a[i]  <= '0;
         end
      end else begin
         if (w_wr & w_hit_ctrl) begin
            r_en     <= PWDATA[0];
            r_irq_en <= PWDATA[1];
         end
         if (w_wr & w_hit_period) begin
            r_period_sh <= PWDATA[CNT_W-1:0];
         end
         if (w_load) begin
            r_period_a <= r_period_sh;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr && (w_idx == 6'(2 + i))) begin
               r_duty_sh[i] <= PWDATA[CNT_W-1:0];
            end
            if (w_load) begin
               r_duty_a[i] <= r_duty_sh[i];
            end
         end

         if (!r_en || w_wrap) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // A wrap in the same cycle as a W1C keeps the flag set
         if (w_wrap) begin
            r_pif <= 1'b1;
         end else if (w_wr & w_hit_status & PWDATA[0]) begin
            r_pif <= 1'b0;
         end

         r_pwm <= w_pwm_next;
         r_irq <= r_pif & r_irq_en;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_hit_ctrl) begin
         w_rdata = {30'd0, r_irq_en, r_en};
      end else if (w_hit_period) begin
         w_rdata = 32'(r_period_sh);
      end else if (w_hit_status) begin
         w_rdata = {31'd0, r_pif};
      end else if (w_hit_count) begin
         w_rdata = 32'(r_cnt);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == 6'(2 + i)) begin
               w_rdata = 32'(r_duty_sh[i]);
            end
         end
      end
   end

   assign PRDATA  = w_rd ? w_rdata : 32'd0;
   assign PREADY  = 1'b1;
   assign PSLVERR = w_access & ~w_valid;
   assign PWM_OUT = r_pwm;
   assign IRQ     = r_irq;

endmodule

`default_nettype wire
